// File: rtl/sqrt_digit_fx.sv
// Unsigned fixed-point square root, restoring radix-2 digit recurrence, Q(W-F).F in and out.
// Latency: N+1 cycles from accepted START to DONE (N+2 with SQRT_DIGIT_ROUND_EN), N=(W+F+1)/2.
// Backpressure: READY low while iterating/rounding; START is ignored (not queued) when READY is low.
// Optional feature: define SQRT_DIGIT_ROUND_EN for round-to-nearest via an extra RND state.
module sqrt_digit_fx #(
  parameter int W = 16,
  parameter int F = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] DATA_IN,
  output logic         READY,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] DATA_OUT
);

  // Iteration count / root width, radicand width, counter width.
  localparam int N  = (W + F + 1) / 2;
  localparam int RW = 2 * N;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
`ifdef SQRT_DIGIT_ROUND_EN
  localparam logic [1:0] S_RND  = 2'd2;
`endif
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]    state;
  logic [RW-1:0] rad;
  logic [N-1:0]  root;
  logic [N+1:0]  rem;
  logic [CW-1:0] cnt;
  logic [W-1:0]  data_out;

  // Next-step signals of the recurrence. The shifted remainder is formed
  // two bits wider than rem so that no bit of rem is silently dropped; the
  // partial remainder never exceeds 2*root, so the upper bits stay zero.
  logic [N+3:0]  rem_wide;
  logic [N+3:0]  trial_wide;
  logic          ge;
  logic [N+1:0]  rem_nxt;
  logic [N:0]    root_ext;
  logic [N-1:0]  root_nxt;

  // One restoring step: bring down two radicand bits, try subtracting 4*root+1.
  always_comb begin
    rem_wide   = {rem, rad[RW-1:RW-2]};
    trial_wide = {2'b00, root, 2'b01};
    ge         = (rem_wide >= trial_wide);
    rem_nxt    = ge ? (N+2)'(rem_wide - trial_wide) : (N+2)'(rem_wide);
    root_ext   = {root, ge};
    root_nxt   = root_ext[N-1:0];
  end

`ifdef SQRT_DIGIT_ROUND_EN
  logic [W:0]   root_inc;
  logic [W-1:0] rnd_val;

  // Round to nearest: remainder above root means the fraction exceeds one half;
  // saturate if the increment would not fit in W bits.
  always_comb begin
    root_inc = (W+1)'(root) + (W+1)'(1);
    rnd_val  = W'(root);
    if (rem > (N+2)'(root)) begin
      rnd_val = root_inc[W] ? {W{1'b1}} : root_inc[W-1:0];
    end
  end
`endif

  // Control FSM plus datapath registers; DATA_OUT only updates when a result completes.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      rad      <= '0;
      root     <= '0;
      rem      <= '0;
      cnt      <= '0;
      data_out <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (START) begin
            rad   <= RW'(DATA_IN) << F;
            root  <= '0;
            rem   <= '0;
            cnt   <= CW'(N - 1);
            state <= S_CALC;
          end
        end
        S_CALC: begin
          rad  <= rad << 2;
          rem  <= rem_nxt;
          root <= root_nxt;
          if (cnt == '0) begin
`ifdef SQRT_DIGIT_ROUND_EN
            state    <= S_RND;
`else
            data_out <= W'(root_nxt);
            state    <= S_FIN;
`endif
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
`ifdef SQRT_DIGIT_ROUND_EN
        S_RND: begin
          data_out <= rnd_val;
          state    <= S_FIN;
        end
`endif
        S_FIN: begin
          // Back-to-back launch: a START in the DONE cycle is accepted directly.
          if (START) begin
            rad   <= RW'(DATA_IN) << F;
            root  <= '0;
            rem   <= '0;
            cnt   <= CW'(N - 1);
            state <= S_CALC;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign READY    = (state == S_IDLE) || (state == S_FIN);
  assign BUSY     = (state == S_CALC);
  assign DONE     = (state == S_FIN);
  assign DATA_OUT = data_out;

endmodule
